// File: rtl/dmux_pkg.sv
// rtl/dmux_pkg.sv - shared channel type and FSM states for the 1x8 demux serial driver
package dmux_pkg;

  localparam int CHAN_W = 3;

  typedef logic [CHAN_W-1:0] chan_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmux18_serial_driver_if.sv
// rtl/dmux18_serial_driver_if.sv - word handshake in, serial bit plus demux select out
interface dmux18_serial_driver_if #(
  parameter int DATA_W = 8
);
  import dmux_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  chan_t             in_chan;
  logic              a;
  logic              e;
  logic              s1;
  logic              s0;
  logic              busy;
  logic              frame_start;
  logic              frame_end;

  modport master (
    output in_valid, in_data, in_chan,
    input  in_ready, a, e, s1, s0, busy, frame_start, frame_end
  );

  modport slave (
    input  in_valid, in_data, in_chan,
    output in_ready, a, e, s1, s0, busy, frame_start, frame_end
  );

endinterface

// File: rtl/dmux_piso.sv
// rtl/dmux_piso.sv - parallel-in serial-out shifter with a registered serial bit
// The first bit is driven straight from the load so it appears the cycle after loading.
module dmux_piso #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              dout_o
);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic              dout_q, dout_d;

  function automatic logic head(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  // Serial bit falls back to 0 whenever neither loading nor shifting.
  always_comb begin
    sr_d   = sr_q;
    dout_d = 1'b0;
    if (load_i) begin
      dout_d = head(data_i);
      sr_d   = advance(data_i);
    end else if (shift_i) begin
      dout_d = head(sr_q);
      sr_d   = advance(sr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      dout_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/dmux18_serial_driver.sv
// rtl/dmux18_serial_driver.sv - serialises words onto the 1x8 demux data input
// Select lines change only on an accepted word so unselected demux outputs never glitch.
module dmux18_serial_driver
  import dmux_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  dmux18_serial_driver_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit BACK_TO_BACK = (GAP_CYCLES == 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  chan_t            sel_q, sel_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             load;
  logic             shift;
  logic             accept;
  logic             serial_bit;

  assign accept = bus.in_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sel_d     = sel_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          sel_d     = bus.in_chan;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          // Without a gap the last bit cycle may accept the next word directly.
          if (BACK_TO_BACK && accept) begin
            bit_cnt_d = '0;
            sel_d     = bus.in_chan;
            load      = 1'b1;
          end else if (BACK_TO_BACK) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          shift     = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    start_d = load;
    end_d   = (state_d == SHIFT) && (bit_cnt_d == BIT_LAST);
    ready_d = (state_d == IDLE) || (BACK_TO_BACK && end_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sel_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sel_q     <= sel_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      end_q     <= end_d;
    end
  end

  dmux_piso #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.in_data),
    .dout_o  (serial_bit)
  );

  assign bus.in_ready    = ready_q;
  assign bus.a           = serial_bit;
  assign bus.e           = sel_q[2];
  assign bus.s1          = sel_q[1];
  assign bus.s0          = sel_q[0];
  assign bus.busy        = busy_q;
  assign bus.frame_start = start_q;
  assign bus.frame_end   = end_q;

endmodule

// File: tb/tb_dmux18_serial_driver.sv
// tb/tb_dmux18_serial_driver.sv - self-checking bench for dmux18_serial_driver
// Three instances: default (gap 1, LSB first), gap 0 (back-to-back), MSB first with gap 2.
module tb_dmux18_serial_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  dmux18_serial_driver_if #(.DATA_W(8)) bus0 ();
  dmux18_serial_driver_if #(.DATA_W(8)) bus1 ();
  dmux18_serial_driver_if #(.DATA_W(8)) bus2 ();

  dmux18_serial_driver #(.DATA_W(8), .GAP_CYCLES(1), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  dmux18_serial_driver #(.DATA_W(8), .GAP_CYCLES(0), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  dmux18_serial_driver #(.DATA_W(8), .GAP_CYCLES(2), .LSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct packed {
    logic       a;
    logic [2:0] sel;
    logic       busy;
    logic       fs;
    logic       fe;
    logic       rdy;
  } obs_t;

  obs_t exp_q[$];

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
  endfunction

  function automatic bit lsb_of(input int k);
    return (k != 2);
  endfunction

  // Expected per-cycle outputs of one whole frame (bit cycles then gap cycles).
  function automatic void push_frame(input int k, input logic [7:0] d, input logic [2:0] c);
    obs_t o;
    for (int i = 0; i < 8; i++) begin
      int pos;
      pos    = lsb_of(k) ? i : 7 - i;
      o      = '0;
      o.a    = d[pos];
      o.sel  = c;
      o.busy = 1'b1;
      o.fs   = (i == 0);
      o.fe   = (i == 7);
      o.rdy  = (gap_of(k) == 0) && (i == 7);
      exp_q.push_back(o);
    end
    for (int g = 0; g < gap_of(k); g++) begin
      o      = '0;
      o.sel  = c;
      o.busy = 1'b1;
      exp_q.push_back(o);
    end
  endfunction

  function automatic void push_idle(input logic [2:0] c);
    obs_t o;
    o     = '0;
    o.sel = c;
    o.rdy = 1'b1;
    exp_q.push_back(o);
  endfunction

  function automatic obs_t sample(input int k);
    obs_t o;
    case (k)
      0: o = {bus0.a, bus0.e, bus0.s1, bus0.s0, bus0.busy, bus0.frame_start, bus0.frame_end, bus0.in_ready};
      1: o = {bus1.a, bus1.e, bus1.s1, bus1.s0, bus1.busy, bus1.frame_start, bus1.frame_end, bus1.in_ready};
      default: o = {bus2.a, bus2.e, bus2.s1, bus2.s0, bus2.busy, bus2.frame_start, bus2.frame_end, bus2.in_ready};
    endcase
    return o;
  endfunction

  // Two 1x4 demuxes, e picks the half, {s1,s0} picks the line inside it.
  function automatic logic [7:0] demux(input logic a, input logic [2:0] sel);
    logic [3:0] one;
    logic [3:0] lo;
    logic [3:0] hi;
    one = 4'b0001;
    lo  = (a && !sel[2]) ? (one << sel[1:0]) : 4'd0;
    hi  = (a &&  sel[2]) ? (one << sel[1:0]) : 4'd0;
    return {hi, lo};
  endfunction

  task automatic drive(input int k, input logic v, input logic [7:0] d, input logic [2:0] c);
    case (k)
      0: begin bus0.in_valid = v; bus0.in_data = d; bus0.in_chan = c; end
      1: begin bus1.in_valid = v; bus1.in_data = d; bus1.in_chan = c; end
      default: begin bus2.in_valid = v; bus2.in_data = d; bus2.in_chan = c; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    obs_t e;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 1'b1, 8'($urandom), 3'($urandom));
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00, 3'd0);
    e = '0;
    e.rdy = 1'b1;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 3; k++) begin
        o = sample(k);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL reset dut%0d cycle %0d: got %b expected %b", k, n, o, e);
        end
      end
      step();
    end
  endtask

  task automatic test_basic();
    obs_t o;
    logic [7:0] y_exp;
    exp_q.delete();
    push_frame(0, 8'hA5, 3'b101);
    push_idle(3'b101);
    drive(0, 1'b1, 8'hA5, 3'b101);
    step();
    drive(0, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      o = sample(0);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL basic cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      y_exp = exp_q[i].a ? 8'h20 : 8'h00;
      checks++;
      if (demux(bus0.a, {bus0.e, bus0.s1, bus0.s0}) !== y_exp) begin
        errors++;
        $display("FAIL basic_y cycle %0d: got %b expected %b", i,
                 demux(bus0.a, {bus0.e, bus0.s1, bus0.s0}), y_exp);
      end
      if (i < exp_q.size() - 1) step();
    end
  endtask

  task automatic test_hold_busy();
    obs_t o;
    logic [7:0] first;
    first = 8'($urandom);
    exp_q.delete();
    push_frame(0, first, 3'd4);
    push_idle(3'd4);
    drive(0, 1'b1, first, 3'd4);
    step();
    drive(0, 1'b1, 8'h3C, 3'd2);
    for (int i = 0; i < exp_q.size(); i++) begin
      o = sample(0);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL hold_first cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      if (i < exp_q.size() - 1) step();
    end
    step();
    drive(0, 1'b0, 8'h00, 3'd0);
    exp_q.delete();
    push_frame(0, 8'h3C, 3'd2);
    push_idle(3'd2);
    for (int i = 0; i < exp_q.size(); i++) begin
      o = sample(0);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL hold_second cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      if (i < exp_q.size() - 1) step();
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_q.delete();
    push_frame(1, 8'hFF, 3'd0);
    push_frame(1, 8'h01, 3'd7);
    push_idle(3'd7);
    drive(1, 1'b1, 8'hFF, 3'd0);
    step();
    drive(1, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      o = sample(1);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      if (i == 7) drive(1, 1'b1, 8'h01, 3'd7);
      if (i == 8) drive(1, 1'b0, 8'h00, 3'd0);
      if (i < exp_q.size() - 1) step();
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    obs_t e;
    exp_q.delete();
    push_frame(0, 8'hF0, 3'd3);
    drive(0, 1'b1, 8'hF0, 3'd3);
    step();
    drive(0, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < 4; i++) begin
      o = sample(0);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid bit %0d: got %b expected %b", i, o, exp_q[i]);
      end
      if (i == 3) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    e = '0;
    e.rdy = 1'b1;
    for (int n = 0; n < 10; n++) begin
      o = sample(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid after %0d: got %b expected %b", n, o, e);
      end
      step();
    end
  endtask

  task automatic test_msb_first();
    obs_t o;
    exp_q.delete();
    push_frame(2, 8'h80, 3'd1);
    push_idle(3'd1);
    drive(2, 1'b1, 8'h80, 3'd1);
    step();
    drive(2, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      o = sample(2);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL msb_first cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      if (i < exp_q.size() - 1) step();
    end
  endtask

  task automatic test_random();
    obs_t o;
    int k;
    logic [7:0] d;
    logic [2:0] c;
    for (int t = 0; t < 12; t++) begin
      k = int'($urandom_range(0, 2));
      d = 8'($urandom);
      c = 3'($urandom);
      exp_q.delete();
      push_frame(k, d, c);
      push_idle(c);
      drive(k, 1'b1, d, c);
      step();
      drive(k, 1'b0, 8'h00, 3'd0);
      for (int i = 0; i < exp_q.size(); i++) begin
        o = sample(k);
        checks++;
        if (o !== exp_q[i]) begin
          errors++;
          $display("FAIL random t%0d dut%0d cycle %0d: got %b expected %b", t, k, i, o, exp_q[i]);
        end
        if (i < exp_q.size() - 1) step();
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00, 3'd0);
    @(negedge clk);
    test_reset();
    test_basic();
    step();
    test_hold_busy();
    step();
    test_back_to_back();
    step();
    test_reset_mid();
    test_msb_first();
    step();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
